// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter that shares one i2c_master_top register
// engine between NUM_REQ level-request / one-cycle-ack requesters.
module i2c_req_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_rd,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [8*NUM_REQ-1:0] req_dev_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_rd_ack,
  output logic [NUM_REQ-1:0]   req_wr_ack,
  output logic [7:0]           req_rdata,
  output logic                 req_error,
  output logic                 m_read_req,
  output logic                 m_write_req,
  input  logic                 m_read_req_ack,
  input  logic                 m_write_req_ack,
  output logic [7:0]           m_dev_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_write_data,
  input  logic [7:0]           m_read_data,
  input  logic                 m_error,
  output logic                 busy,
  output logic [1:0]           grant_idx,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             state;
  logic [1:0]         last_grant;
  logic               op_read;
  logic [NUM_REQ-1:0] active;
  logic               found;
  logic [1:0]         next_idx;
  int                 best_dist;
  int                 cand_dist;
  logic [7:0]         sel_dev;
  logic [7:0]         sel_reg;
  logic [7:0]         sel_wdata;
  logic               sel_rd;
  logic [NUM_REQ-1:0] grant_oh;
  logic               op_done;

  assign active  = req_rd | req_wr;
  assign op_done = op_read ? m_read_req_ack : m_write_req_ack;

  // Round-robin pick: distance 0 is the requester just after last_grant.
  always_comb begin
    found     = 1'b0;
    next_idx  = '0;
    best_dist = NUM_REQ;
    cand_dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_dist = (i + 2 * NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
      if (active[i] && (cand_dist < best_dist)) begin
        best_dist = cand_dist;
        next_idx  = 2'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dev   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (2'(i) == next_idx) begin
        sel_dev   = req_dev_addr[8*i +: 8];
        sel_reg   = req_reg_addr[8*i +: 8];
        sel_wdata = req_wdata[8*i +: 8];
        sel_rd    = req_rd[i];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (2'(i) == grant_idx);
    end
  end

  // Reads win over writes from the same requester; the write gets a later grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      last_grant   <= 2'(NUM_REQ - 1);
      grant_idx    <= '0;
      op_read      <= 1'b0;
      m_read_req   <= 1'b0;
      m_write_req  <= 1'b0;
      m_dev_addr   <= '0;
      m_reg_addr   <= '0;
      m_write_data <= '0;
      req_rd_ack   <= '0;
      req_wr_ack   <= '0;
      req_rdata    <= '0;
      req_error    <= 1'b0;
      err_count    <= '0;
    end else begin
      req_rd_ack <= '0;
      req_wr_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx    <= next_idx;
            last_grant   <= next_idx;
            m_dev_addr   <= sel_dev;
            m_reg_addr   <= sel_reg;
            m_write_data <= sel_wdata;
            op_read      <= sel_rd;
            m_read_req   <= sel_rd;
            m_write_req  <= ~sel_rd;
            busy         <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (op_done) begin
            m_read_req  <= 1'b0;
            m_write_req <= 1'b0;
            if (op_read) begin
              req_rd_ack <= grant_oh;
              req_rdata  <= m_read_data;
            end else begin
              req_wr_ack <= grant_oh;
            end
            req_error <= m_error;
            if (m_error && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy        <= 1'b0;
          m_read_req  <= 1'b0;
          m_write_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed bench with a transaction-level reference model
// of the arbiter, a responsive master model and auto-dropping requesters.
module tb_i2c_req_arbiter;
  localparam int N = 2;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_rd, req_wr;
  logic [W-1:0] req_dev_addr, req_reg_addr, req_wdata;
  logic [N-1:0] req_rd_ack, req_wr_ack;
  logic [7:0]   req_rdata;
  logic         req_error;
  logic         m_read_req, m_write_req, m_read_req_ack, m_write_req_ack;
  logic [7:0]   m_dev_addr, m_reg_addr, m_write_data, m_read_data;
  logic         m_error, busy;
  logic [1:0]   grant_idx;
  logic [7:0]   err_count;

  int errors = 0;
  int checks = 0;

  int         lat;
  logic [7:0] rd_value;
  logic       err_value;
  bit         stray;
  int         m_cnt;
  int         rem_rd[N], rem_wr[N];
  int         rd_pulses[N], wr_pulses[N];
  int         cyc, master_ack_cyc, req_ack_cyc;
  int         gap_low;
  bit         seen_fall, prev_mreq;
  int         obs_grant[$];
  int         obs_rd[$];
  int         exp_g[4] = '{0, 1, 0, 1};

  // Reference model: one open transaction at most, one quiet cycle after each ack.
  bit           mo_open, mo_hold, mo_op_rd;
  int           mo_owner, mo_last, mo_errs, e_grant;
  logic [7:0]   e_dev, e_reg, e_wd, e_rdata;
  logic         e_error;
  logic [N-1:0] e_rd_ack, e_wr_ack;

  i2c_req_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .req_rd_ack(req_rd_ack), .req_wr_ack(req_wr_ack),
    .req_rdata(req_rdata), .req_error(req_error),
    .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_read_req_ack(m_read_req_ack), .m_write_req_ack(m_write_req_ack),
    .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_error(m_error),
    .busy(busy), .grant_idx(grant_idx), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    mo_open = 0; mo_hold = 0; mo_op_rd = 0;
    mo_owner = 0; mo_last = N - 1; mo_errs = 0; e_grant = 0;
    e_dev = '0; e_reg = '0; e_wd = '0; e_rdata = '0; e_error = 1'b0;
    e_rd_ack = '0; e_wr_ack = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] act, rdv;
    e_rd_ack = '0;
    e_wr_ack = '0;
    if (!rst_n) begin
      model_reset();
    end else if (mo_hold) begin
      mo_hold = 0;
    end else if (mo_open) begin
      if ((mo_op_rd && m_read_req_ack) || (!mo_op_rd && m_write_req_ack)) begin
        mo_open = 0;
        mo_hold = 1;
        if (mo_op_rd) begin
          e_rd_ack = N'(1) << mo_owner;
          e_rdata  = m_read_data;
        end else begin
          e_wr_ack = N'(1) << mo_owner;
        end
        e_error = m_error;
        if (m_error) mo_errs++;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c   = (mo_last + k) % N;
        act = (req_rd | req_wr) >> c;
        rdv = req_rd >> c;
        if (!mo_open && act[0]) begin
          mo_open  = 1;
          mo_owner = c;
          mo_last  = c;
          e_grant  = c;
          mo_op_rd = rdv[0];
          e_dev    = 8'(req_dev_addr >> (8 * c));
          e_reg    = 8'(req_reg_addr >> (8 * c));
          e_wd     = 8'(req_wdata >> (8 * c));
        end
      end
    end
  endtask

  task automatic tick();
    bit mreq;
    @(posedge clk);
    model_step();
    #2;
    cyc++;
    m_read_req_ack  = 1'b0;
    m_write_req_ack = 1'b0;
    m_error         = 1'b0;
    m_read_data     = 8'hEE;
    if (m_read_req || m_write_req) begin
      m_cnt++;
      if (m_cnt == lat) begin
        m_read_req_ack  = m_read_req;
        m_write_req_ack = m_write_req;
        m_read_data     = m_read_req ? rd_value : 8'h3C;
        m_error         = err_value;
        master_ack_cyc  = cyc;
      end else if (stray && m_cnt == 1) begin
        m_read_req_ack  = m_write_req;
        m_write_req_ack = m_read_req;
        m_error         = 1'b1;
      end
    end else begin
      m_cnt = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_rd_ack[i]) begin
        rd_pulses[i]++;
        rem_rd[i]--;
        req_rd[i]   = (rem_rd[i] > 0);
        req_ack_cyc = cyc;
      end
      if (req_wr_ack[i]) begin
        wr_pulses[i]++;
        rem_wr[i]--;
        req_wr[i]   = (rem_wr[i] > 0);
        req_ack_cyc = cyc;
      end
    end
    mreq = m_read_req | m_write_req;
    if (mreq && !prev_mreq) begin
      if (seen_fall) checkOutput("mreq_gap_ge2", 32'(gap_low >= 2), 32'd1);
      obs_grant.push_back(int'(grant_idx));
      obs_rd.push_back(int'(m_read_req));
    end
    if (!mreq && prev_mreq) begin
      seen_fall = 1;
      gap_low   = 0;
    end
    if (!mreq) gap_low++;
    prev_mreq = mreq;
    @(negedge clk);
    checkOutput("m_read_req",   32'(m_read_req),   32'(mo_open && mo_op_rd));
    checkOutput("m_write_req",  32'(m_write_req),  32'(mo_open && !mo_op_rd));
    checkOutput("busy",         32'(busy),         32'(mo_open || mo_hold));
    checkOutput("grant_idx",    32'(grant_idx),    e_grant);
    checkOutput("m_dev_addr",   32'(m_dev_addr),   32'(e_dev));
    checkOutput("m_reg_addr",   32'(m_reg_addr),   32'(e_reg));
    checkOutput("m_write_data", 32'(m_write_data), 32'(e_wd));
    checkOutput("req_rd_ack",   32'(req_rd_ack),   32'(e_rd_ack));
    checkOutput("req_wr_ack",   32'(req_wr_ack),   32'(e_wr_ack));
    checkOutput("req_rdata",    32'(req_rdata),    32'(e_rdata));
    checkOutput("req_error",    32'(req_error),    32'(e_error));
    checkOutput("err_count",    32'(err_count),    (mo_errs > 255) ? 32'd255 : 32'(mo_errs));
  endtask

  task automatic applyStimulus(input int idx, input int nrd, input int nwr,
                               input logic [7:0] dev, input logic [7:0] regad, input logic [7:0] wd);
    rem_rd[idx] = nrd;
    rem_wr[idx] = nwr;
    if (nrd > 0) req_rd = req_rd | (N'(1) << idx);
    else         req_rd = req_rd & ~(N'(1) << idx);
    if (nwr > 0) req_wr = req_wr | (N'(1) << idx);
    else         req_wr = req_wr & ~(N'(1) << idx);
    req_dev_addr = (req_dev_addr & ~(W'(8'hFF) << (8 * idx))) | (W'(dev) << (8 * idx));
    req_reg_addr = (req_reg_addr & ~(W'(8'hFF) << (8 * idx))) | (W'(regad) << (8 * idx));
    req_wdata    = (req_wdata & ~(W'(8'hFF) << (8 * idx))) | (W'(wd) << (8 * idx));
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (rem_rd[i] > 0 || rem_wr[i] > 0) p = 1;
    return p;
  endfunction

  task automatic runUntilQuiet(input int budget, input string name);
    int n = 0;
    bit quiet;
    do begin
      tick();
      n++;
      quiet = !pending() && !mo_open && !mo_hold;
    end while (!quiet && n < budget);
    checkOutput({name, "_completed"}, 32'(quiet), 32'd1);
  endtask

  task automatic clearObs();
    obs_grant.delete();
    obs_rd.delete();
    for (int i = 0; i < N; i++) begin
      rd_pulses[i] = 0;
      wr_pulses[i] = 0;
    end
  endtask

  initial begin
    req_rd = '0; req_wr = '0;
    req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
    m_read_req_ack = 1'b0; m_write_req_ack = 1'b0; m_read_data = 8'hEE; m_error = 1'b0;
    lat = 4; rd_value = 8'h00; err_value = 1'b0; stray = 0; m_cnt = 0;
    cyc = 0; master_ack_cyc = 0; req_ack_cyc = 0; gap_low = 0; seen_fall = 0; prev_mreq = 0;
    for (int i = 0; i < N; i++) begin
      rem_rd[i] = 0;
      rem_wr[i] = 0;
    end
    clearObs();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_grant_idx",   32'(grant_idx),   32'd0);
    checkOutput("rst_err_count",   32'(err_count),   32'd0);
    checkOutput("rst_m_write_req", 32'(m_write_req), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single write from requester 0");
    clearObs();
    lat = 50;
    applyStimulus(0, 0, 1, 8'h72, 8'h08, 8'h35);
    tick();
    checkOutput("t1_m_write_req",  32'(m_write_req),  32'd1);
    checkOutput("t1_m_dev_addr",   32'(m_dev_addr),   32'h72);
    checkOutput("t1_m_reg_addr",   32'(m_reg_addr),   32'h08);
    checkOutput("t1_m_write_data", 32'(m_write_data), 32'h35);
    runUntilQuiet(200, "t1");
    checkOutput("t1_ack_latency", req_ack_cyc - master_ack_cyc, 32'd1);
    checkOutput("t1_wr_pulses",   wr_pulses[0], 32'd1);
    checkOutput("t1_req_error",   32'(req_error), 32'd0);
    checkOutput("t1_err_count",   32'(err_count), 32'd0);

    $display("[TB] read from requester 1, then a write that must keep rdata");
    clearObs();
    lat = 6; rd_value = 8'hA5; stray = 1;
    applyStimulus(1, 1, 0, 8'h60, 8'h05, 8'h00);
    runUntilQuiet(100, "t2_read");
    checkOutput("t2_rd_pulses", rd_pulses[1], 32'd1);
    checkOutput("t2_req_rdata", 32'(req_rdata), 32'hA5);
    stray = 0;
    applyStimulus(1, 0, 1, 8'h60, 8'h10, 8'h77);
    runUntilQuiet(100, "t2_write");
    checkOutput("t2_rdata_held", 32'(req_rdata), 32'hA5);
    checkOutput("t2_wr_pulses",  wr_pulses[1], 32'd1);

    $display("[TB] contention between requesters 0 and 1");
    clearObs();
    lat = 3;
    applyStimulus(0, 0, 2, 8'h10, 8'h20, 8'h30);
    applyStimulus(1, 0, 2, 8'h11, 8'h21, 8'h31);
    runUntilQuiet(100, "t3");
    checkOutput("t3_grant_count", obs_grant.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_grant.size(); i++) begin
      checkOutput($sformatf("t3_grant%0d", i), obs_grant[i], exp_g[i]);
    end

    $display("[TB] error path and saturation");
    clearObs();
    lat = 2; err_value = 1'b1;
    applyStimulus(0, 0, 3, 8'h22, 8'h33, 8'h44);
    runUntilQuiet(100, "t4_three");
    checkOutput("t4_err_count3", 32'(err_count), 32'd3);
    checkOutput("t4_req_error",  32'(req_error), 32'd1);
    lat = 1;
    applyStimulus(1, 0, 300, 8'h23, 8'h34, 8'h45);
    runUntilQuiet(2000, "t4_sat");
    checkOutput("t4_err_count_sat", 32'(err_count), 32'd255);
    err_value = 1'b0;

    $display("[TB] read and write from the same requester");
    clearObs();
    lat = 3; rd_value = 8'h5A;
    applyStimulus(0, 1, 1, 8'h50, 8'h01, 8'h99);
    runUntilQuiet(100, "t5");
    checkOutput("t5_txn_count", obs_rd.size(), 32'd2);
    if (obs_rd.size() == 2) begin
      checkOutput("t5_first_is_read",   obs_rd[0], 32'd1);
      checkOutput("t5_second_is_write", obs_rd[1], 32'd0);
      checkOutput("t5_second_grant",    obs_grant[1], 32'd0);
    end
    checkOutput("t5_req_rdata", 32'(req_rdata), 32'h5A);

    $display("[TB] reset in the middle of a transaction");
    clearObs();
    lat = 20;
    applyStimulus(0, 0, 1, 8'h72, 8'h40, 8'h41);
    repeat (5) tick();
    checkOutput("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_m_write_req", 32'(m_write_req), 32'd0);
    checkOutput("t6_busy",        32'(busy),        32'd0);
    checkOutput("t6_err_count",   32'(err_count),   32'd0);
    checkOutput("t6_acks",        32'({req_rd_ack, req_wr_ack}), 32'd0);
    checkOutput("t6_grant_idx",   32'(grant_idx),   32'd0);
    model_reset();
    req_rd = '0; req_wr = '0;
    for (int i = 0; i < N; i++) begin
      rem_rd[i] = 0;
      rem_wr[i] = 0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clearObs();
    lat = 3;
    applyStimulus(0, 0, 1, 8'h01, 8'h02, 8'h03);
    applyStimulus(1, 0, 1, 8'h04, 8'h05, 8'h06);
    runUntilQuiet(100, "t6_after");
    checkOutput("t6_grant_count", obs_grant.size(), 32'd2);
    if (obs_grant.size() == 2) begin
      checkOutput("t6_first_grant",  obs_grant[0], 32'd0);
      checkOutput("t6_second_grant", obs_grant[1], 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
